// File: rtl/program_rom_loader.sv
// Instruction ROM with an in-system byte-stream loader: serves fetches in RUN,
// accepts a length-framed, XOR-checked image while holding the CPU.
module program_rom_loader #(
  parameter int unsigned ADDR_WIDTH     = 14,
  parameter int unsigned DEPTH          = 16384,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                  iCpuClock,
  input  logic                  iCpuReset,
  input  logic [ADDR_WIDTH-1:0] iFetchAddr,
  output logic [31:0]           oInstruction,
  input  logic                  iLoadRequest,
  input  logic                  iByteValid,
  input  logic [7:0]            iByteData,
  output logic                  oByteReady,
  output logic                  oCpuHold,
  output logic                  oLoadDone,
  output logic                  oLoadError,
  output logic [ADDR_WIDTH:0]   oWordCount
);

  localparam int unsigned WC_W   = ADDR_WIDTH + 1;
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CKSUM  = 3'd4,
    ABORT  = 3'd5
  } state_t;

  logic [31:0] mem [DEPTH];

  state_t              state, stateNext;
  logic [15:0]         lenReg, lenNext;
  logic [23:0]         wordBuf, wordBufNext;
  logic [1:0]          byteIdx, byteIdxNext;
  logic [7:0]          cksum, cksumNext;
  logic [IDLE_W-1:0]   idleCnt, idleNext;
  logic [WC_W-1:0]     wordCountNext;
  logic                loadDoneNext, loadErrorNext;

  logic                  accept;
  logic [15:0]           lenFull;
  logic [WC_W-1:0]       wcInc;
  logic [IDLE_W-1:0]     idleInc;
  logic                  memWe_c;
  logic [ADDR_WIDTH-1:0] memAddr_c;
  logic [31:0]           memData_c;

  assign accept    = iByteValid && oByteReady;
  assign lenFull   = {iByteData, lenReg[7:0]};
  assign wcInc     = oWordCount + WC_W'(1);
  assign idleInc   = idleCnt + IDLE_W'(1);
  assign memAddr_c = oWordCount[ADDR_WIDTH-1:0];
  assign memData_c = {iByteData, wordBuf};

  // Next-state and datapath update
  always_comb begin
    stateNext     = state;
    lenNext       = lenReg;
    wordBufNext   = wordBuf;
    byteIdxNext   = byteIdx;
    cksumNext     = cksum;
    idleNext      = idleCnt;
    wordCountNext = oWordCount;
    loadDoneNext  = oLoadDone;
    loadErrorNext = oLoadError;
    memWe_c       = 1'b0;

    case (state)
      RUN: begin
        if (iLoadRequest) begin
          stateNext     = LEN_LO;
          loadDoneNext  = 1'b0;
          loadErrorNext = 1'b0;
          wordCountNext = '0;
          cksumNext     = '0;
          byteIdxNext   = '0;
          idleNext      = '0;
        end
      end
      LEN_LO: begin
        if (accept) begin
          lenNext[7:0] = iByteData;
          stateNext    = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept) begin
          lenNext[15:8] = iByteData;
          if (lenFull == 16'd0 || 32'(lenFull) > DEPTH) stateNext = ABORT;
          else                                           stateNext = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          cksumNext = cksum ^ iByteData;
          case (byteIdx)
            2'd0:    begin wordBufNext[7:0]   = iByteData; byteIdxNext = 2'd1; end
            2'd1:    begin wordBufNext[15:8]  = iByteData; byteIdxNext = 2'd2; end
            2'd2:    begin wordBufNext[23:16] = iByteData; byteIdxNext = 2'd3; end
            default: begin
              memWe_c       = iCpuReset;
              wordCountNext = wcInc;
              byteIdxNext   = 2'd0;
              if (32'(wcInc) == 32'(lenReg)) stateNext = CKSUM;
            end
          endcase
        end
      end
      CKSUM: begin
        if (accept) begin
          if (iByteData == cksum) begin
            stateNext    = RUN;
            loadDoneNext = 1'b1;
          end else begin
            stateNext = ABORT;
          end
        end
      end
      ABORT: begin
        loadErrorNext = 1'b1;
        stateNext     = RUN;
      end
      default: stateNext = RUN;
    endcase

    // Inter-byte watchdog, only while a byte is expected
    if (oByteReady) begin
      if (accept)                              idleNext = '0;
      else if (32'(idleInc) >= TIMEOUT_CYCLES) stateNext = ABORT;
      else                                     idleNext = idleInc;
    end
  end

  always_ff @(posedge iCpuClock) begin
    if (!iCpuReset) begin
      state        <= RUN;
      lenReg       <= '0;
      wordBuf      <= '0;
      byteIdx      <= '0;
      cksum        <= '0;
      idleCnt      <= '0;
      oWordCount   <= '0;
      oLoadDone    <= 1'b0;
      oLoadError   <= 1'b0;
      oByteReady   <= 1'b0;
      oCpuHold     <= 1'b0;
      oInstruction <= '0;
    end else begin
      state        <= stateNext;
      lenReg       <= lenNext;
      wordBuf      <= wordBufNext;
      byteIdx      <= byteIdxNext;
      cksum        <= cksumNext;
      idleCnt      <= idleNext;
      oWordCount   <= wordCountNext;
      oLoadDone    <= loadDoneNext;
      oLoadError   <= loadErrorNext;
      oByteReady   <= (stateNext inside {LEN_LO, LEN_HI, DATA, CKSUM});
      oCpuHold     <= (stateNext != RUN);
      oInstruction <= (state == RUN) ? mem[iFetchAddr] : 32'd0;
    end
  end

  // Word array has no reset so images survive a CPU reset
  always_ff @(posedge iCpuClock) begin
    if (memWe_c) mem[memAddr_c] <= memData_c;
  end

endmodule
